// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU feeding the accumulator; shift-add MUL, single-cycle others.
// result/zero/carry register on the edge that raises done; acc_load mirrors done.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic             acc_load,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_SHL   = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MULT, FIN} state_t;

    state_t             state, state_nx;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a, b;
    logic [2*WIDTH-1:0] mcand, prod, prod_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     alu_w;
    logic               accept, last;

    assign accept   = (state == IDLE) && start;
    assign last     = cnt == CNT_W'(WIDTH - 1);
    assign busy     = state != IDLE;
    assign done     = state == FIN;
    assign acc_load = done;
    // b doubles as the multiplier during MULT, consumed LSB first
    assign prod_nx  = prod + (b[0] ? mcand : '0);

    // Top bit of alu_w is the carry/borrow flag for single-cycle ops
    always_comb begin
        alu_w = '0;
        case (op)
            OP_PASSA: alu_w = {1'b0, a};
            OP_ADD:   alu_w = {1'b0, a} + {1'b0, b};
            OP_SUB:   alu_w = {1'b0, a} - {1'b0, b};
            OP_AND:   alu_w = {1'b0, a & b};
            OP_XOR:   alu_w = {1'b0, a ^ b};
            OP_PASSB: alu_w = {1'b0, b};
            OP_SHL:   alu_w = {a, 1'b0};
            default:  alu_w = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (opcode == OP_MUL) ? MULT : EXEC;
            EXEC:    state_nx = FIN;
            MULT:    if (last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op    <= opcode;
                a     <= in_a;
                b     <= in_b;
                mcand <= {{WIDTH{1'b0}}, in_a};
                prod  <= '0;
                cnt   <= '0;
            end
            if (state == EXEC) begin
                result <= alu_w[WIDTH-1:0];
                zero   <= alu_w[WIDTH-1:0] == '0;
                carry  <= alu_w[WIDTH];
            end
            if (state == MULT) begin
                prod  <= prod_nx;
                mcand <= mcand << 1;
                b     <= b >> 1;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    result <= prod_nx[WIDTH-1:0];
                    zero   <= prod_nx[WIDTH-1:0] == '0;
                    carry  <= |prod_nx[2*WIDTH-1:WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 0, rst_n = 1, start = 0;
    logic [2:0]   opcode = '0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         busy, done, acc_load, zero, carry;
    logic [W-1:0] result;
    int           checks = 0, failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .acc_load(acc_load), .result(result), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input int a, input int b, output int r, output int c);
        int m, s;
        m = 1 << W;
        c = 0;
        case (op)
            3'd0: r = a;
            3'd1: begin s = a + b; r = s % m; c = int'(s >= m); end
            3'd2: begin r = (a - b + m) % m; c = int'(a < b); end
            3'd3: r = a & b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            3'd6: begin s = a * b; r = s % m; c = int'(s >= m); end
            default: begin s = a * 2; r = s % m; c = int'(s >= m); end
        endcase
    endfunction

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int er, ec, lat;
        logic [W-1:0] prev;
        model(op, a, b, er, ec);
        prev = result;
        @(negedge clk);
        start = 1; opcode = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        chk("busy_accept", busy, 1);
        @(negedge clk);
        start = hold; opcode = 3'($urandom); in_a = W'($urandom); in_b = W'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!done) begin
                chk("busy_run", busy, 1);
                chk("result_held", result, prev);
            end
        end
        chk("latency", lat, op == 3'b110 ? W + 1 : 2);
        chk("result", result, er);
        chk("zero", zero, int'(er == 0));
        chk("carry", carry, ec);
        chk("acc_load", acc_load, 1);
        chk("busy_fin", busy, 1);
        @(posedge clk); #1;
        chk("done_drop", done, 0);
        chk("acc_load_drop", acc_load, 0);
        chk("busy_drop", busy, 0);
        chk("result_after", result, er);
    endtask

    initial begin
        bit saw;
        #2 rst_n = 0;
        #5;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, carry}, 0);
        @(negedge clk) rst_n = 1;

        run(3'b001, 8'h33, 8'h44, 0);
        @(negedge clk);
        start = 1; opcode = 3'b110; in_a = 8'h0F; in_b = 8'h11;
        @(posedge clk);
        @(negedge clk) start = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_acc_load", acc_load, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {zero, carry}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        saw = 0;
        repeat (15) begin
            @(posedge clk); #1;
            saw |= done;
        end
        chk("midrst_no_done", saw, 0);

        run(3'b001, 8'hF0, 8'h20, 0);
        chk("add_k", {carry, zero, result}, {2'b10, 8'h10});
        run(3'b010, 8'h05, 8'h05, 0);
        chk("sub_eq_k", {carry, zero, result}, {2'b01, 8'h00});
        run(3'b010, 8'h03, 8'h04, 0);
        chk("sub_borrow_k", {carry, result}, {1'b1, 8'hFF});
        run(3'b110, 8'h0F, 8'h11, 0);
        chk("mul_k", {carry, result}, {1'b0, 8'hFF});
        run(3'b110, 8'h20, 8'h10, 0);
        chk("mul_ovf_k", {carry, zero, result}, {2'b11, 8'h00});
        run(3'b111, 8'h81, 8'h00, 0);
        chk("shl_k", {carry, result}, {1'b1, 8'h02});
        run(3'b011, 8'hF0, 8'h0F, 0);
        chk("and_k", zero, 1);
        run(3'b101, 8'h00, 8'h5A, 0);
        chk("passb_k", result, 8'h5A);

        run(3'b001, 8'h7F, 8'h01, 1);
        run(3'b100, 8'hA5, 8'h5A, 1);
        run(3'b110, 8'hFF, 8'hFF, 1);
        start = 0;

        for (int i = 0; i < 40; i++)
            run(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        start = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
